wb_skid_reg: RTL and testbench
==============================

WB_SKID_REG -- requirements
Module: wb_skid_reg

Interface
REQ-001 Parameter M, default 32: width of data, ALU result and PC+4 paths.
REQ-002 Parameter N, default 5: destination-register index width.
REQ-003 Parameter CW, default 16: stall-counter width (used only with WB_STALL_CNT_EN).
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 validM  in  1  memory stage presents a valid instruction.
REQ-007 readyM  out  1  block can accept an instruction this cycle.
REQ-008 RD  in  M  data-memory read data.
REQ-009 ALUM  in  M  ALU result, memory stage.
REQ-010 writeRM  in  N  destination register, memory stage.
REQ-011 pcPlusM  in  M  PC+4 of instruction, memory stage.
REQ-012 regWriteM  in  1  instruction writes register file.
REQ-013 memToRegM  in  1  result source select (1 = RD, 0 = ALUM).
REQ-014 flushW  in  1  discard all held instructions.
REQ-015 readyW  in  1  writeback consumer accepts the head instruction.
REQ-016 validW  out  1  head entry valid.
REQ-017 RDW, ALUW, pcPlusW  out  M each; writeRW  out  N: head entry fields.
REQ-018 regWriteW  out  1  head regWrite AND validW.
REQ-019 resultW  out  M  memToReg(head) ? RDW : ALUW, combinational from head.
REQ-020 stallCntW  out  CW  present only with WB_STALL_CNT_EN.

Function
REQ-021 Storage: two entries, main (head, drives outputs) and skid; each holds RD, ALUM, writeRM, pcPlusM, regWriteM, memToRegM plus a valid bit.
REQ-022 readyM = NOT skid.valid; registered state only, no combinational path from readyW or validM.
REQ-023 Accept = validM AND readyM; drain = validW AND readyW.
REQ-024 Main empty, or main draining with skid empty: accepted entry loads main next edge.
REQ-025 Main full, not draining, accept: entry loads skid; readyM falls next cycle.
REQ-026 Drain with skid full: skid moves to main, skid clears; no accept possible that cycle (readyM=0).
REQ-027 Drain, no accept, skid empty: main.valid clears.
REQ-028 No accept, no drain: all state holds; outputs stable (payload stable while validW=1 and readyW=0).
REQ-029 Latency: accepted entry appears at outputs one cycle after accept when it enters main; order strictly FIFO; no drop, no duplication.
REQ-030 Payload registers load only on accept/shift; invalid entries' payload is don't-care but SHALL NOT alter regWriteW (gated).
REQ-031 flushW=1: both valid bits clear next edge; accept in same cycle discarded; flushW wins over accept and drain.
REQ-032 validM=0 with readyM=1: no state change from input side.

Reset
REQ-033 RST=1 at rising edge: main.valid, skid.valid cleared; validW=0, regWriteW=0, readyM=1 next cycle.
REQ-034 RST=1 also zeroes RDW, ALUW, writeRW, pcPlusW, resultW and stallCntW.
REQ-035 RST wins over flushW, accept and drain; mid-operation reset drops all held entries.

Configuration
REQ-036 Macro WB_STALL_CNT_EN defined: stallCntW increments each cycle validW=1 AND readyW=0, saturates at all-ones, clears only on RST (not on flushW).
REQ-037 Macro undefined: stallCntW port and counter absent; all other behaviour identical.

Verification
REQ-038 Reset then validM=1, ALUM=0x0000_0010, writeRM=3, regWriteM=1, memToRegM=0, readyW=1 -> next cycle validW=1, resultW=0x10, writeRW=3, regWriteW=1.
REQ-039 readyW=0, send A, B -> A at head, B in skid, readyM=0; readyW=1 -> A then B on consecutive cycles, readyM=1 after B reaches main.
REQ-040 Two entries held, flushW=1 with validM=1 -> next cycle validW=0, readyM=1, new entry not present.
REQ-041 memToRegM=1, RD=0xDEAD_BEEF, ALUM=0x1 -> resultW=0xDEAD_BEEF; RST asserted while two entries held -> validW=0, outputs zero next cycle.
REQ-042 WB_STALL_CNT_EN, CW=4: hold readyW=0 with validW=1 for 20 cycles -> stallCntW=15 saturated; flushW leaves it 15; RST -> 0.

Source files
------------

// File: rtl/wb_skid_reg.sv
// wb_skid_reg: two-entry writeback skid register (main head + skid), registered readyM.
// Optional macro WB_STALL_CNT_EN adds a saturating stall counter on output stallCntW.
module wb_skid_reg #(
    parameter int M = 32,
    parameter int N = 5
`ifdef WB_STALL_CNT_EN
    ,
    parameter int CW = 16
`endif
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         validM,
    output logic         readyM,
    input  logic [M-1:0] RD,
    input  logic [M-1:0] ALUM,
    input  logic [N-1:0] writeRM,
    input  logic [M-1:0] pcPlusM,
    input  logic         regWriteM,
    input  logic         memToRegM,
    input  logic         flushW,
    input  logic         readyW,
    output logic         validW,
    output logic [M-1:0] RDW,
    output logic [M-1:0] ALUW,
    output logic [M-1:0] pcPlusW,
    output logic [N-1:0] writeRW,
    output logic         regWriteW,
`ifdef WB_STALL_CNT_EN
    output logic [CW-1:0] stallCntW,
`endif
    output logic [M-1:0] resultW
);
    typedef struct packed {
        logic [M-1:0] rd;
        logic [M-1:0] alu;
        logic [M-1:0] pc;
        logic [N-1:0] wr;
        logic         rw;
        logic         mtr;
    } ent_t;

    ent_t r_main, r_skid;
    logic r_mv, r_sv;
    ent_t w_in;
    logic w_acc, w_drn;

    assign w_in  = '{rd: RD, alu: ALUM, pc: pcPlusM, wr: writeRM, rw: regWriteM, mtr: memToRegM};
    assign w_acc = validM & ~r_sv;
    assign w_drn = r_mv & readyW;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mv   <= 1'b0;
            r_sv   <= 1'b0;
            r_main <= '0;
            r_skid <= '0;
        end else if (flushW) begin
            r_mv <= 1'b0;
            r_sv <= 1'b0;
        end else if (!r_mv || (w_drn && !r_sv)) begin
            r_mv <= w_acc;
            if (w_acc) r_main <= w_in;
        end else if (w_drn) begin
            // skid full means readyM was low, so no accept can collide with the shift
            r_main <= r_skid;
            r_sv   <= 1'b0;
        end else if (w_acc) begin
            r_skid <= w_in;
            r_sv   <= 1'b1;
        end
    end

    assign readyM    = ~r_sv;
    assign validW    = r_mv;
    assign RDW       = r_main.rd;
    assign ALUW      = r_main.alu;
    assign pcPlusW   = r_main.pc;
    assign writeRW   = r_main.wr;
    assign regWriteW = r_main.rw & r_mv;
    assign resultW   = r_main.mtr ? r_main.rd : r_main.alu;

`ifdef WB_STALL_CNT_EN
    logic [CW-1:0] r_stall;
    always_ff @(posedge CLK) begin
        if (RST) r_stall <= '0;
        else if (r_mv && !readyW && !(&r_stall)) r_stall <= r_stall + 1'b1;
    end
    assign stallCntW = r_stall;
`endif
endmodule

// File: tb/tb_wb_skid_reg.sv
// tb_wb_skid_reg: scoreboard bench; stimulus pushes expected entries, a monitor pops on each drain.
module tb_wb_skid_reg;
    localparam int M = 32;
    localparam int N = 5;
`ifdef WB_STALL_CNT_EN
    localparam int CW = 4;
    logic [CW-1:0] stallCntW;
`endif

    logic CLK = 1'b0, RST = 1'b1, validM = 1'b0, flushW = 1'b0, readyW = 1'b0;
    logic regWriteM = 1'b0, memToRegM = 1'b0;
    logic [M-1:0] RD = '0, ALUM = '0, pcPlusM = '0;
    logic [N-1:0] writeRM = '0;
    logic readyM, validW, regWriteW;
    logic [M-1:0] RDW, ALUW, pcPlusW, resultW;
    logic [N-1:0] writeRW;

    wb_skid_reg #(
        .M(M),
        .N(N)
`ifdef WB_STALL_CNT_EN
        ,
        .CW(CW)
`endif
    ) dut (
        .CLK(CLK), .RST(RST), .validM(validM), .readyM(readyM), .RD(RD), .ALUM(ALUM),
        .writeRM(writeRM), .pcPlusM(pcPlusM), .regWriteM(regWriteM), .memToRegM(memToRegM),
        .flushW(flushW), .readyW(readyW), .validW(validW), .RDW(RDW), .ALUW(ALUW),
        .pcPlusW(pcPlusW), .writeRW(writeRW), .regWriteW(regWriteW),
`ifdef WB_STALL_CNT_EN
        .stallCntW(stallCntW),
`endif
        .resultW(resultW)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  wr;
        logic        rw;
        logic        mtr;
    } vec_t;

    vec_t vt [13];
    vec_t q[$];
    vec_t m_e;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive(input int i);
        RD = vt[i].rd; ALUM = vt[i].alu; pcPlusM = vt[i].pc;
        writeRM = vt[i].wr; regWriteM = vt[i].rw; memToRegM = vt[i].mtr;
    endtask

    task automatic send(input int i);
        bit ok;
        ok = 0;
        drive(i);
        validM = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge CLK);
            if (readyM) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: vector %0d readyM stayed %b, required 1", i, readyM);
        end
        @(posedge CLK);
        if (ok) q.push_back(vt[i]);
        #1;
        validM = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (!RST && !flushW && validW && readyW) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL drain_unexpected: got result %h wr %0d with no entry expected", resultW, writeRW);
            end else begin
                m_e = q.pop_front();
                if (resultW !== m_e.res || writeRW !== m_e.wr || regWriteW !== m_e.rw ||
                    pcPlusW !== m_e.pc || RDW !== m_e.rd || ALUW !== m_e.alu)
                begin
                    errors++;
                    $display("FAIL drain_entry: got res=%h wr=%0d rw=%b pc=%h rd=%h alu=%h expected res=%h wr=%0d rw=%b pc=%h rd=%h alu=%h",
                             resultW, writeRW, regWriteW, pcPlusW, RDW, ALUW,
                             m_e.res, m_e.wr, m_e.rw, m_e.pc, m_e.rd, m_e.alu);
                end
            end
        end
    end

    initial begin
        vt[0]  = '{rd: 32'h0,        alu: 32'h10,       pc: 32'h104, res: 32'h10,       wr: 5'd3,  rw: 1, mtr: 0};
        vt[1]  = '{rd: 32'hAAAA0001, alu: 32'h11111111, pc: 32'h108, res: 32'hAAAA0001, wr: 5'd5,  rw: 1, mtr: 1};
        vt[2]  = '{rd: 32'h0BADF00D, alu: 32'h22222222, pc: 32'h10C, res: 32'h22222222, wr: 5'd6,  rw: 1, mtr: 0};
        vt[3]  = '{rd: 32'hDEADBEEF, alu: 32'h1,        pc: 32'h110, res: 32'hDEADBEEF, wr: 5'd7,  rw: 1, mtr: 1};
        vt[4]  = '{rd: 32'h5,        alu: 32'h33,       pc: 32'h114, res: 32'h33,       wr: 5'd31, rw: 0, mtr: 0};
        vt[5]  = '{rd: 32'h44,       alu: 32'h12345678, pc: 32'h118, res: 32'h44,       wr: 5'd1,  rw: 1, mtr: 1};
        vt[6]  = '{rd: 32'hFFFFFFFF, alu: 32'h0,        pc: 32'h11C, res: 32'h0,        wr: 5'd2,  rw: 1, mtr: 0};
        vt[7]  = '{rd: 32'h77,       alu: 32'h7070,     pc: 32'h120, res: 32'h7070,     wr: 5'd8,  rw: 1, mtr: 0};
        vt[8]  = '{rd: 32'h88,       alu: 32'h8080,     pc: 32'h124, res: 32'h88,       wr: 5'd10, rw: 1, mtr: 1};
        vt[9]  = '{rd: 32'h99,       alu: 32'h9090,     pc: 32'h128, res: 32'h9090,     wr: 5'd11, rw: 1, mtr: 0};
        vt[10] = '{rd: 32'hA0,       alu: 32'hA0A0,     pc: 32'h12C, res: 32'hA0A0,     wr: 5'd12, rw: 1, mtr: 0};
        vt[11] = '{rd: 32'hB0,       alu: 32'hB0B0,     pc: 32'h130, res: 32'hB0,       wr: 5'd13, rw: 1, mtr: 1};
        vt[12] = '{rd: 32'h0,        alu: 32'hCAFE,     pc: 32'h200, res: 32'hCAFE,     wr: 5'd9,  rw: 1, mtr: 0};

        // reset state
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_validW", validW, 0);
        chk("rst_readyM", readyM, 1);
        chk("rst_regWriteW", regWriteW, 0);
        chk("rst_resultW", resultW, 0);
        tick(1);

        // single transfer, result from ALU
        readyW = 1'b1;
        send(0);
        tick(2);

        // backpressure: A in main, B in skid, then drain in order
        readyW = 1'b0;
        send(1);
        send(2);
        @(negedge CLK);
        chk("bp_readyM", readyM, 0);
        chk("bp_validW", validW, 1);
        chk("bp_head_alu", ALUW, vt[1].alu);
        tick(1);
        readyW = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        chk("bp_readyM_after", readyM, 1);
        chk("bp_validW_B", validW, 1);
        tick(2);

        // back-to-back stream including memToReg select and gated regWrite
        send(3);
        send(4);
        send(5);
        send(6);
        chk("stream_readyM", readyM, 1);
        tick(3);

        // flush with two entries held
        readyW = 1'b0;
        send(7);
        send(8);
        drive(9);
        validM = 1'b1;
        flushW = 1'b1;
        tick(1);
        flushW = 1'b0;
        validM = 1'b0;
        q.delete();
        @(negedge CLK);
        chk("flush2_validW", validW, 0);
        chk("flush2_readyM", readyM, 1);
        chk("flush2_regWriteW", regWriteW, 0);
        @(negedge CLK);
        chk("flush2_no_new", validW, 0);
        tick(1);

        // flush with one entry held and an accept that must be dropped
        send(7);
        drive(9);
        validM = 1'b1;
        flushW = 1'b1;
        tick(1);
        flushW = 1'b0;
        validM = 1'b0;
        q.delete();
        @(negedge CLK);
        chk("flush1_validW", validW, 0);
        readyW = 1'b1;
        tick(3);

        // reset while two entries held
        readyW = 1'b0;
        send(10);
        send(11);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        q.delete();
        @(negedge CLK);
        chk("mrst_validW", validW, 0);
        chk("mrst_readyM", readyM, 1);
        chk("mrst_regWriteW", regWriteW, 0);
        chk("mrst_resultW", resultW, 0);
        chk("mrst_RDW", RDW, 0);
        chk("mrst_ALUW", ALUW, 0);
        chk("mrst_writeRW", 32'(writeRW), 0);
        chk("mrst_pcPlusW", pcPlusW, 0);
        tick(1);
        readyW = 1'b1;
        send(12);
        tick(3);

`ifdef WB_STALL_CNT_EN
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("stall_rst", 32'(stallCntW), 0);
        readyW = 1'b0;
        send(0);
        tick(20);
        chk("stall_sat", 32'(stallCntW), 15);
        flushW = 1'b1;
        tick(1);
        flushW = 1'b0;
        q.delete();
        tick(1);
        chk("stall_flush", 32'(stallCntW), 15);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("stall_clear", 32'(stallCntW), 0);
        readyW = 1'b1;
        tick(1);
`endif

        chk("queue_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
